// File: rtl/rsqrt_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rsqrt_arbiter_if : requester-side and core-side bus of rsqrt_arbiter     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface rsqrt_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   i_req;
    logic [8*N_REQ-1:0] i_data;
    logic [N_REQ-1:0]   o_gnt;
    logic [N_REQ-1:0]   o_done;
    logic [31:0]        o_result;
    logic               o_err;
    logic               o_busy;
    logic               o_core_enb;
    logic [7:0]         o_core_data;
    logic               i_core_valid;
    logic [31:0]        i_core_data;

    // The arbiter itself.
    modport slave (
        input  i_req, i_data, i_core_valid, i_core_data,
        output o_gnt, o_done, o_result, o_err, o_busy, o_core_enb, o_core_data
    );

    // Requesters plus the reciprocal_sqrt core, seen from outside the arbiter.
    modport master (
        output i_req, i_data, i_core_valid, i_core_data,
        input  o_gnt, o_done, o_result, o_err, o_busy, o_core_enb, o_core_data
    );
endinterface
`default_nettype wire

// File: rtl/rsqrt_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rsqrt_arbiter : round-robin sharing of one reciprocal_sqrt core          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module rsqrt_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input  wire logic      i_clk,
    input  wire logic      i_rst,
    rsqrt_arbiter_if.slave bus
);
    localparam int c_PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int c_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
    localparam logic [c_PTR_W-1:0] c_IDX_LAST = c_PTR_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0]   c_ONE      = {{(N_REQ-1){1'b0}}, 1'b1};

    logic [1:0]         state_q,  state_d;
    logic [c_PTR_W-1:0] rr_q,     rr_d;
    logic [c_PTR_W-1:0] owner_q,  owner_d;
    logic [c_CNT_W-1:0] cnt_q,    cnt_d;
    logic [N_REQ-1:0]   gnt_q,    gnt_d;
    logic [N_REQ-1:0]   done_q,   done_d;
    logic [31:0]        result_q, result_d;
    logic               err_q,    err_d;
    logic               busy_q,   busy_d;
    logic               enb_q,    enb_d;
    logic [7:0]         cdata_q,  cdata_d;

    logic               w_any;
    logic [c_PTR_W-1:0] w_pick;

    // Round-robin pick: first pass covers indices at/after the pointer,
    // second pass wraps around to the ones below it.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (!w_any && bus.i_req[j] && (c_PTR_W'(j) >= rr_q)) begin
                w_any  = 1'b1;
                w_pick = c_PTR_W'(j);
            end
        end
        for (int j = 0; j < N_REQ; j++) begin
            if (!w_any && bus.i_req[j]) begin
                w_any  = 1'b1;
                w_pick = c_PTR_W'(j);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q  <= c_IDLE;
            rr_q     <= '0;
            owner_q  <= '0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            enb_q    <= 1'b0;
            cdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            result_q <= result_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            enb_q    <= enb_d;
            cdata_q  <= cdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:  if (w_any) state_d = c_ISSUE;
            c_ISSUE: state_d = bus.i_core_valid ? c_DONE : c_WAIT;
            c_WAIT:  if (bus.i_core_valid || (cnt_q == c_CNT_LAST)) state_d = c_DONE;
            c_DONE:  state_d = c_IDLE;
            default: state_d = c_IDLE;
        endcase
    end

    // Valid is tested before the counter so a result landing on the last
    // WAIT cycle is still delivered rather than reported as a timeout.
    always_comb begin
        rr_d     = rr_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        gnt_d    = '0;
        done_d   = '0;
        enb_d    = 1'b0;
        cdata_d  = cdata_q;
        result_d = result_q;
        err_d    = err_q;
        busy_d   = (state_d != c_IDLE);
        case (state_q)
            c_IDLE: begin
                if (w_any) begin
                    owner_d = w_pick;
                    gnt_d   = c_ONE << w_pick;
                    enb_d   = 1'b1;
                    cdata_d = bus.i_data[{w_pick, 3'b000} +: 8];
                end
            end
            c_ISSUE: begin
                cnt_d = '0;
                if (bus.i_core_valid) begin
                    result_d = bus.i_core_data;
                    err_d    = 1'b0;
                    done_d   = c_ONE << owner_q;
                end
            end
            c_WAIT: begin
                if (bus.i_core_valid) begin
                    result_d = bus.i_core_data;
                    err_d    = 1'b0;
                    done_d   = c_ONE << owner_q;
                end else if (cnt_q == c_CNT_LAST) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    done_d   = c_ONE << owner_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            c_DONE: begin
                rr_d = (owner_q == c_IDX_LAST) ? '0 : owner_q + 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.o_gnt       = gnt_q;
    assign bus.o_done      = done_q;
    assign bus.o_result    = result_q;
    assign bus.o_err       = err_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_core_enb  = enb_q;
    assign bus.o_core_data = cdata_q;

endmodule
`default_nettype wire

// File: tb/tb_rsqrt_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rsqrt_arbiter : random requesters + latency-programmable core model   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_rsqrt_arbiter;
    localparam int N_REQ     = 4;
    localparam int TIMEOUT   = 64;
    localparam int LAT_NEVER = 1000;
    localparam int LAT_RAND  = -1;

    localparam int M_OFF    = 0;
    localparam int M_SINGLE = 1;
    localparam int M_ALL    = 2;
    localparam int M_RAND   = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rsqrt_arbiter_if #(.N_REQ(N_REQ)) bus ();

    rsqrt_arbiter #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
        .i_clk (clk),
        .i_rst (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // stimulus control
    int         mode = M_OFF;
    int         single_k = 0;
    logic [7:0] single_d = 8'h00;
    bit         single_fired = 1'b0;
    int         lat_sel = 0;
    bit         spur_en = 1'b0;
    logic [N_REQ-1:0] req = '0;
    logic [7:0] data [N_REQ];

    // transaction-level reference model
    int          m_rr = 0;
    bit          m_active = 1'b0;
    int          m_owner = 0;
    int          m_gnt_cyc = 0;
    int          m_done_cyc = 0;
    logic [7:0]  m_op = 8'h00;
    logic [31:0] m_exp_res = '0;
    bit          m_exp_err = 1'b0;
    logic [31:0] m_last_res = '0;
    int          cur_lat = 0;

    // core model
    bit          c_pend = 1'b0;
    int          c_cyc = 0;
    logic [31:0] c_res = '0;

    function automatic logic [31:0] core_f(input logic [7:0] x);
        return {~x, x, 8'h5A, x};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int pick_lat();
        int r;
        if (lat_sel != LAT_RAND) return lat_sel;
        r = int'($urandom_range(9));
        if (r <= 5) return r;
        if (r == 6) return int'($urandom_range(20, 6));
        if (r == 7) return TIMEOUT;
        if (r == 8) return TIMEOUT + 1;
        return LAT_NEVER;
    endfunction

    task automatic set_mode(input int m);
        mode = m;
        single_fired = 1'b0;
    endtask

    // One clock: check outputs, play the core, drive requesters, then let the
    // model decide what the next edge should start.  rst_next is the reset
    // level applied at the coming edge.
    task automatic step(input bit rst_next);
        logic [N_REQ-1:0] exp_gnt;
        logic [N_REQ-1:0] exp_done;
        bit               in_reset;
        bit               is_gnt;
        bit               is_done;
        int               pick;
        @(posedge clk);
        #1;
        cyc++;
        in_reset = !rst_n;
        if (in_reset) begin
            m_active   = 1'b0;
            m_rr       = 0;
            m_last_res = '0;
        end
        if (m_active && cyc > m_done_cyc) m_active = 1'b0;
        is_gnt   = m_active && (cyc == m_gnt_cyc);
        is_done  = m_active && (cyc == m_done_cyc);
        exp_gnt  = '0;
        exp_done = '0;
        if (is_gnt)  exp_gnt[m_owner]  = 1'b1;
        if (is_done) exp_done[m_owner] = 1'b1;
        if (is_done) m_last_res = m_exp_res;

        check("gnt", 32'(bus.o_gnt), 32'(exp_gnt));
        check("core_enb", 32'(bus.o_core_enb), 32'(is_gnt));
        if (is_gnt) check("core_data", 32'(bus.o_core_data), 32'(m_op));
        check("done", 32'(bus.o_done), 32'(exp_done));
        check("result", bus.o_result, m_last_res);
        if (is_done) check("err", 32'(bus.o_err), 32'(m_exp_err));
        if (in_reset) check("err_rst", 32'(bus.o_err), 32'd0);
        check("busy", 32'(bus.o_busy), 32'(m_active && cyc >= m_gnt_cyc));

        // core: answers what the DUT actually issued, after cur_lat cycles
        if (bus.o_core_enb && cur_lat != LAT_NEVER) begin
            c_pend = 1'b1;
            c_cyc  = cyc + cur_lat;
            c_res  = core_f(bus.o_core_data);
        end
        if (c_pend && cyc == c_cyc) begin
            bus.i_core_valid = 1'b1;
            bus.i_core_data  = c_res;
            c_pend = 1'b0;
        end else if (spur_en && (!bus.o_busy || bus.o_done != '0) && $urandom_range(3) == 0) begin
            bus.i_core_valid = 1'b1;
            bus.i_core_data  = 32'hDEAD_0000 | 32'($urandom_range(16'hFFFF));
        end else begin
            bus.i_core_valid = 1'b0;
            bus.i_core_data  = $urandom;
        end

        for (int k = 0; k < N_REQ; k++) begin
            case (mode)
                M_ALL: begin
                    if (bus.o_gnt[k] || !req[k]) data[k] = 8'($urandom);
                    req[k] = 1'b1;
                end
                M_SINGLE: begin
                    if (k != single_k) req[k] = 1'b0;
                    else if (bus.o_gnt[k]) req[k] = 1'b0;
                    else if (!single_fired) begin
                        req[k]  = 1'b1;
                        data[k] = single_d;
                        single_fired = 1'b1;
                    end
                end
                M_RAND: begin
                    if (req[k]) begin
                        if (bus.o_gnt[k] || $urandom_range(40) == 0) req[k] = 1'b0;
                    end else if ($urandom_range(6) == 0) begin
                        req[k]  = 1'b1;
                        data[k] = 8'($urandom);
                    end
                end
                default: req[k] = 1'b0;
            endcase
            bus.i_data[8*k +: 8] = data[k];
        end
        bus.i_req = req;

        if (rst_next && !m_active && req != '0) begin
            pick = -1;
            for (int i = 0; i < N_REQ; i++) begin
                int idx;
                idx = (m_rr + i) % N_REQ;
                if (pick < 0 && req[idx]) pick = idx;
            end
            cur_lat    = pick_lat();
            m_owner    = pick;
            m_op       = data[pick];
            m_gnt_cyc  = cyc + 1;
            if (cur_lat <= TIMEOUT) begin
                m_done_cyc = cyc + 2 + cur_lat;
                m_exp_res  = core_f(m_op);
                m_exp_err  = 1'b0;
            end else begin
                m_done_cyc = cyc + 2 + TIMEOUT;
                m_exp_res  = '0;
                m_exp_err  = 1'b1;
            end
            m_rr     = (pick + 1) % N_REQ;
            m_active = 1'b1;
        end
        rst_n = rst_next;
    endtask

    initial begin
        rst_n            = 1'b0;
        bus.i_req        = '0;
        bus.i_data       = '0;
        bus.i_core_valid = 1'b0;
        bus.i_core_data  = '0;
        for (int k = 0; k < N_REQ; k++) data[k] = 8'h00;

        // reset hold, then idle with no requests
        repeat (5) step(1'b0);
        repeat (20) step(1'b1);

        // zero-latency core, requester 2 with operand 8'h10
        lat_sel = 0;
        single_k = 2; single_d = 8'h10; set_mode(M_SINGLE);
        repeat (6) step(1'b1);
        set_mode(M_RAND);
        repeat (150) step(1'b1);

        // latency 5, all requesters held: rotation from pointer 0
        set_mode(M_OFF);
        repeat (3) step(1'b0);
        lat_sel = 5; set_mode(M_ALL);
        repeat (60) step(1'b1);
        set_mode(M_OFF);
        repeat (10) step(1'b1);

        // silent core: timeout on requester 1, then a normal op on requester 3
        lat_sel = LAT_NEVER;
        single_k = 1; single_d = 8'h77; set_mode(M_SINGLE);
        repeat (75) step(1'b1);
        lat_sel = 3;
        single_k = 3; single_d = 8'hC3; set_mode(M_SINGLE);
        repeat (10) step(1'b1);

        // random traffic, random latencies incl. timeout boundaries, spurious valids
        lat_sel = LAT_RAND; spur_en = 1'b1; set_mode(M_RAND);
        repeat (3000) step(1'b1);
        spur_en = 1'b0; set_mode(M_OFF);
        repeat (80) step(1'b1);

        // reset while waiting; the core's late answer must be ignored
        lat_sel = 20;
        single_k = 2; single_d = 8'h3E; set_mode(M_SINGLE);
        repeat (10) step(1'b1);
        set_mode(M_OFF);
        repeat (2) step(1'b0);
        repeat (30) step(1'b1);
        lat_sel = 1; set_mode(M_ALL);
        repeat (12) step(1'b1);
        set_mode(M_OFF);
        repeat (6) step(1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
